// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA multiplier arbiter: the 3-bit FSM state
// encoding and the default WAIT timeout formula.
// No ports (package).
// ----------------------------------------------------------------------------
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ABORT = 3'd4
  } arb_state_t;

  // Worst-case multiplier latency is assumed to scale with operand width;
  // the fixed margin covers short operands.
  function automatic int default_timeout(input int data_width);
    return 4 * data_width + 8;
  endfunction

endpackage

// File: rtl/rsa_mult_arbiter_if.sv
// ----------------------------------------------------------------------------
// rsa_mult_arbiter_if
// Bus between the arbiter and the shared multiplier.
//   m_start : start pulse to the multiplier (arbiter -> multiplier)
//   m_a/m_b : operands, DATA_WIDTH each      (arbiter -> multiplier)
//   m_done  : product complete flag          (multiplier -> arbiter)
//   m_c     : product, 2*DATA_WIDTH          (multiplier -> arbiter)
// Modports: master = arbiter side, slave = multiplier side.
// ----------------------------------------------------------------------------
interface rsa_mult_arbiter_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                      m_start;
  logic [DATA_WIDTH-1:0]     m_a;
  logic [DATA_WIDTH-1:0]     m_b;
  logic                      m_done;
  logic [2*DATA_WIDTH-1:0]   m_c;

  modport master (
    output m_start, m_a, m_b,
    input  m_done, m_c
  );

  modport slave (
    input  m_start, m_a, m_b,
    output m_done, m_c
  );

endinterface

// File: rtl/rsa_rr_arb2.sv
// ----------------------------------------------------------------------------
// rsa_rr_arb2
// Two-way round-robin grant. When both requesters are valid the pointer
// selects the winner; otherwise the single valid requester wins.
//   valid[1:0] : request bits
//   ptr        : requester holding priority on a tie
//   grant[1:0] : one-hot grant (zero when nothing is valid)
// ----------------------------------------------------------------------------
module rsa_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rsa_mult_arbiter.sv
// ----------------------------------------------------------------------------
// rsa_mult_arbiter
// Shares one external multiplier between two requesters. Accepts an operand
// pair, starts the multiplier, waits (with timeout) for the product and
// returns it to the owning requester with a done pulse.
//   arb_clk, arb_rst        : clock, async active-low reset
//   reqN_valid/a/b          : operand request from requester N
//   reqN_ready              : acceptance (combinational, IDLE only)
//   reqN_done/err           : one-cycle completion pulse, err=1 on timeout
//   reqN_c                  : last product delivered to requester N
//   m_bus                   : multiplier bus (master side)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a request; grant and latch operands
// ST_ISSUE | m_start high for one cycle
// ST_WAIT  | counting cycles until m_done or timeout
// ST_RESP  | done pulse to owner, err=0 (product captured on entry)
// ST_ABORT | done pulse to owner, err=1, result left unchanged
// ----------------------------------------------------------------------------
module rsa_mult_arbiter
  import rsa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = default_timeout(DATA_WIDTH)
) (
  input  logic                    arb_clk,
  input  logic                    arb_rst,
  input  logic                    req0_valid,
  input  logic [DATA_WIDTH-1:0]   req0_a,
  input  logic [DATA_WIDTH-1:0]   req0_b,
  output logic                    req0_ready,
  output logic                    req0_done,
  output logic                    req0_err,
  output logic [2*DATA_WIDTH-1:0] req0_c,
  input  logic                    req1_valid,
  input  logic [DATA_WIDTH-1:0]   req1_a,
  input  logic [DATA_WIDTH-1:0]   req1_b,
  output logic                    req1_ready,
  output logic                    req1_done,
  output logic                    req1_err,
  output logic [2*DATA_WIDTH-1:0] req1_c,
  rsa_mult_arbiter_if.master      m_bus
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_t               state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     m_start_q, m_start_d;
  logic [DATA_WIDTH-1:0]    m_a_q, m_a_d;
  logic [DATA_WIDTH-1:0]    m_b_q, m_b_d;
  logic [1:0]               done_q, done_d;
  logic [1:0]               err_q, err_d;
  logic [2*DATA_WIDTH-1:0]  c0_q, c0_d;
  logic [2*DATA_WIDTH-1:0]  c1_q, c1_d;

  logic [1:0] valid_vec;
  logic [1:0] grant;
  logic [1:0] ready;

  assign valid_vec = {req1_valid, req0_valid};

  rsa_rr_arb2 u_rr_arb (
    .valid (valid_vec),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Gated by reset as well so ready reads 0 while arb_rst is held low.
  assign ready = (state_q == ST_IDLE && arb_rst) ? grant : 2'b00;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    m_start_d = 1'b0;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    c0_d      = c0_q;
    c1_d      = c1_q;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d   = ST_ISSUE;
          owner_d   = grant[1];
          ptr_d     = ~grant[1];   // the other requester wins the next tie
          m_start_d = 1'b1;
          m_a_d     = grant[1] ? req1_a : req0_a;
          m_b_d     = grant[1] ? req1_b : req0_b;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (m_bus.m_done) begin
          state_d         = ST_RESP;
          done_d[owner_q] = 1'b1;
          m_a_d           = '0;
          m_b_d           = '0;
          if (owner_q) c1_d = m_bus.m_c;
          else         c0_d = m_bus.m_c;
        end else if (cnt_q == CNT_MAX) begin
          state_d         = ST_ABORT;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          m_a_d           = '0;
          m_b_d           = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP, ST_ABORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge arb_clk or negedge arb_rst) begin
    if (!arb_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      m_start_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      c0_q      <= '0;
      c1_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      m_start_q <= m_start_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      done_q    <= done_d;
      err_q     <= err_d;
      c0_q      <= c0_d;
      c1_q      <= c1_d;
    end
  end

  assign m_bus.m_start = m_start_q;
  assign m_bus.m_a     = m_a_q;
  assign m_bus.m_b     = m_b_q;

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_c     = c0_q;
  assign req1_c     = c1_q;

endmodule

// File: doc/rsa_mult_arbiter.md
RSA_MULT_ARBITER -- requirements
Module: rsa_mult_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set the operand width; the product width is 2*DATA_WIDTH.
REQ-002 Parameter TIMEOUT, default 4*DATA_WIDTH+8, shall set the maximum number of WAIT cycles before abort.
REQ-003 arb_clk  in  1  shall be the single clock; every register updates on its rising edge.
REQ-004 arb_rst  in  1  shall be the reset, asynchronous and active-low.
REQ-005 reqN_valid  in  1 (N=0,1)  shall indicate that requester N presents an operand pair.
REQ-006 reqN_a, reqN_b  in  DATA_WIDTH  shall carry the operands of requester N.
REQ-007 reqN_ready  out  1  shall mark the cycle in which requester N's operands are accepted.
REQ-008 reqN_done  out  1  shall be a one-cycle pulse marking that requester N's result is complete.
REQ-009 reqN_err  out  1  shall be valid with reqN_done; 1 means timeout abort.
REQ-010 reqN_c  out  2*DATA_WIDTH  shall hold requester N's last result, stable until its next reqN_done.
REQ-011 m_start  out  1  shall be the start pulse to the shared multiplier.
REQ-012 m_a, m_b  out  DATA_WIDTH  shall carry the operands to the multiplier.
REQ-013 m_done, m_c  in  1, 2*DATA_WIDTH  shall carry the multiplier's completion flag and product.

Function
REQ-014 The FSM shall have the states IDLE, ISSUE, WAIT, RESP and ABORT.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready that same cycle (combinational), register its operands and owner ID, and go to ISSUE; otherwise stay.
REQ-016 Arbitration shall be round-robin: when both are valid, grant the requester not granted last; pointer reset value selects requester 0 first.
REQ-017 reqN_ready shall be asserted only in IDLE, and for at most one requester.
REQ-018 ISSUE: assert m_start for exactly one cycle with the registered operands on m_a/m_b, then go to WAIT.
REQ-019 m_a/m_b shall hold the registered operands from ISSUE until the FSM leaves WAIT.
REQ-020 WAIT: count cycles from 0; on m_done=1, capture m_c into the owner's reqN_c and go to RESP.
REQ-021 WAIT: if the count reaches TIMEOUT with no m_done, go to ABORT.
REQ-022 RESP: pulse the owner's reqN_done with reqN_err=0, then go to IDLE.
REQ-023 ABORT: pulse the owner's reqN_done with reqN_err=1, leave reqN_c unchanged, then go to IDLE.
REQ-024 m_done seen outside WAIT shall be ignored; it captures nothing and generates no pulse.
REQ-025 Request-to-start latency: m_start shall rise exactly one cycle after the reqN_ready cycle.
REQ-026 Completion latency: reqN_done shall rise exactly one cycle after the m_done cycle captured in WAIT.
REQ-027 A requester deasserting valid after acceptance shall not affect the operation in flight.
REQ-028 reqN_done and reqN_ready of the same requester shall never be high in the same cycle.
REQ-029 The WAIT counter shall saturate at TIMEOUT and shall be sized $clog2(TIMEOUT+1).

Reset
REQ-030 On arb_rst=0 the block shall immediately enter IDLE, clear the owner and round-robin pointer to 0, and clear the WAIT counter.
REQ-031 On arb_rst=0 these outputs shall be 0: m_start, m_a, m_b, reqN_ready, reqN_done, reqN_err, reqN_c.
REQ-032 A reset during WAIT shall abandon the operation with no reqN_done; the later m_done shall be ignored per REQ-024.

Structure
REQ-033 State encodings (3-bit) and the default TIMEOUT formula shall live in a shared package, rsa_pkg.
REQ-034 The round-robin grant logic shall be one sub-module, rsa_rr_arb2, taking 2 valid bits plus the pointer and producing a one-hot grant.
REQ-035 The multiplier shall be instantiated outside this block; the arbiter connects only through the m_* ports.

Verification
REQ-036 req0 only, a=8'd13, b=8'd11 -> one m_start pulse, then req0_done=1, req0_err=0, req0_c=16'd143.
REQ-037 req0 and req1 valid in the same cycle, both held -> req0 served first, then req1; grants alternate 0,1,0,1 over four back-to-back pairs.
REQ-038 a=8'hFF, b=8'hFF -> req_c=16'hFE01; a=0, b=8'h5A -> req_c=0.
REQ-039 Multiplier model never asserts m_done -> owner's done pulse with err=1 exactly TIMEOUT+2 cycles after m_start; next request served normally.
REQ-040 arb_rst pulsed low mid-WAIT -> all outputs 0 asynchronously, no done pulse; stray m_done afterwards ignored.
REQ-041 Spurious m_done pulse while IDLE -> no reqN_done and reqN_c unchanged.
